lsu_ctrl: RTL and testbench

//  Load/store sequencer between the core's memory stage and the synchronous data BRAM.
//  - Accepts one load/store request per handshake and checks alignment.
//  - Drives byte write-enables and lane-shifted store data to the memory.
//  - Waits the fixed BRAM read latency, then returns the selected byte/half/word

---
 rtl/lsu_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the memory stage and a synchronous data BRAM.
// One request per handshake: alignment check, lane-shifted store, or a load that
// waits the fixed BRAM latency and returns the extended byte/half/word.
module lsu_ctrl #(
  parameter int unsigned MEM_LAT = 1,  // BRAM read latency, 1..4
  parameter int unsigned ADDR_W  = 14  // BRAM word-address width
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [31:0]       req_inst_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_fault_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam logic [6:0] OpLoad  = 7'h03;
  localparam logic [6:0] OpStore = 7'h23;
  localparam logic [2:0] LatLast = 3'(MEM_LAT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;

  logic [6:0]  req_op;
  logic [2:0]  req_f3;
  logic        req_is_load, req_is_store, req_misalign, req_fault;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;

  // Instruction bits and upper address bits outside the BRAM range are don't-care.
  logic unused_req;
  assign unused_req = ^{req_inst_i[31:15], req_inst_i[11:7], req_addr_i[31:ADDR_W+2]};

  // Decode the incoming request: access kind and fault conditions.
  always_comb begin
    req_op       = req_inst_i[6:0];
    req_f3       = req_inst_i[14:12];
    req_is_load  = (req_op == OpLoad);
    req_is_store = (req_op == OpStore);
    case (req_f3[1:0])
      2'b01:   req_misalign = req_addr_i[0];
      2'b10:   req_misalign = (req_addr_i[1:0] != 2'b00);
      default: req_misalign = 1'b0;
    endcase
    req_fault = 1'b0;
    if (req_is_load) begin
      req_fault = (req_f3 == 3'b011) || (req_f3[2:1] == 2'b11) || req_misalign;
    end else if (req_is_store) begin
      req_fault = (req_f3 >= 3'b011) || req_misalign;
    end
  end

  // Select the addressed lane of the read word and sign/zero-extend it.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = mem_rdata_i[7:0];
      2'd1:    byte_sel = mem_rdata_i[15:8];
      2'd2:    byte_sel = mem_rdata_i[23:16];
      default: byte_sel = mem_rdata_i[31:24];
    endcase
    half_sel = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (f3_q[1:0])
      2'b00:   load_ext = {{24{~f3_q[2] & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~f3_q[2] & half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata_i;
    endcase
  end

  // Byte enables and replicated store data for the addressed lanes.
  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        st_we    = 4'b0001 << addr_q[1:0];
        st_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_we    = addr_q[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        st_we    = 4'b1111;
        st_wdata = wdata_q;
      end
    endcase
  end

  // Next-state logic and request/response capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_store_d = is_store_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    fault_d    = fault_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          is_store_d = req_is_store;
          f3_d       = req_f3;
          addr_d     = req_addr_i[ADDR_W+1:0];
          wdata_d    = req_wdata_i;
          rdata_d    = '0;
          fault_d    = req_fault;
          // Faults and non-memory ops never touch the BRAM.
          if (req_fault || !(req_is_load || req_is_store)) state_d = StResp;
          else                                              state_d = StIssue;
        end
      end
      StIssue: begin
        if (is_store_q) begin
          state_d = StResp;
        end else begin
          state_d = StWait;
          cnt_d   = 3'd1;
        end
      end
      StWait: begin
        // cnt_q counts cycles since the strobe; read data is valid when it hits MEM_LAT.
        if (cnt_q == LatLast) begin
          rdata_d = load_ext;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StResp: begin
        if (resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any access in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_store_q <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_store_q <= is_store_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      fault_q    <= fault_d;
    end
  end

  // Outputs decoded from state so that reset clears them without a clock edge.
  always_comb begin
    req_ready_o  = (state_q == StIdle);
    resp_valid_o = (state_q == StResp);
    resp_rdata_o = (state_q == StResp) ? rdata_q : 32'h0;
    resp_fault_o = (state_q == StResp) && fault_q;
    mem_en_o     = (state_q == StIssue);
    mem_addr_o   = (state_q == StIssue) ? addr_q[ADDR_W+1:2] : '0;
    mem_we_o     = (state_q == StIssue && is_store_q) ? st_we : 4'b0000;
    mem_wdata_o  = (state_q == StIssue && is_store_q) ? st_wdata : 32'h0;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: two instances (MEM_LAT 1 and 3), each with a BRAM model,
// checked against a byte-array reference of the load/store rules.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [31:0] req_inst   [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_fault [2];
  logic        mem_en     [2];
  logic [3:0]  mem_we     [2];
  logic [13:0] mem_addr   [2];
  logic [31:0] mem_wdata  [2];
  logic [31:0] mem_rdata  [2];

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [7:0]  ref_bytes [2][1024];
  logic [31:0] last_rdata;
  int          lat_of [2] = '{1, 3};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 1 : 3;
    logic [31:0] mem [256] = '{default: 32'h0};
    logic [31:0] rd_pipe [Lat];

    lsu_ctrl #(.MEM_LAT(Lat), .ADDR_W(14)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid[g]),
      .req_ready_o (req_ready[g]),
      .req_inst_i  (req_inst[g]),
      .req_addr_i  (req_addr[g]),
      .req_wdata_i (req_wdata[g]),
      .resp_valid_o(resp_valid[g]),
      .resp_ready_i(resp_ready[g]),
      .resp_rdata_o(resp_rdata[g]),
      .resp_fault_o(resp_fault[g]),
      .mem_en_o    (mem_en[g]),
      .mem_we_o    (mem_we[g]),
      .mem_addr_o  (mem_addr[g]),
      .mem_wdata_o (mem_wdata[g]),
      .mem_rdata_i (mem_rdata[g])
    );

    // Synchronous BRAM; garbage on the read pipe whenever no access was strobed.
    always @(posedge clk) begin
      if (mem_en[g]) begin
        for (int b = 0; b < 4; b++)
          if (mem_we[g][b]) mem[mem_addr[g][7:0]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
        rd_pipe[0] <= mem[mem_addr[g][7:0]];
      end else begin
        rd_pipe[0] <= $urandom;
      end
      for (int i = 1; i < Lat; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata[g] = rd_pipe[Lat-1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ld(input logic [2:0] f3);
    return {17'h0, f3, 5'd1, 7'h03};
  endfunction

  function automatic logic [31:0] st(input logic [2:0] f3);
    return {17'h0, f3, 5'd0, 7'h23};
  endfunction

  // One full transaction on instance k, starting and ending at a negedge in IDLE.
  task automatic do_txn(input int k, input logic [31:0] inst, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold);
    logic [6:0]  op;
    logic [2:0]  f3;
    int          size, lat_exp;
    bit          is_ld, is_st, flt, mem_op;
    logic [3:0]  we_e;
    logic [31:0] wd_e, rd_e;
    op     = inst[6:0];
    f3     = inst[14:12];
    size   = 1 << f3[1:0];
    is_ld  = (op == 7'h03);
    is_st  = (op == 7'h23);
    flt    = 0;
    if (is_ld && (f3 == 3 || f3 == 6 || f3 == 7)) flt = 1;
    if (is_st && f3 >= 3) flt = 1;
    if ((is_ld || is_st) && !flt && (addr % size) != 0) flt = 1;
    mem_op  = (is_ld || is_st) && !flt;
    lat_exp = !mem_op ? 1 : (is_st ? 2 : 2 + lat_of[k]);
    we_e = 4'h0;
    wd_e = 32'h0;
    rd_e = 32'h0;
    if (mem_op && is_st) begin
      for (int j = 0; j < 4; j++) wd_e[8*j +: 8] = wdata[8*(j % size) +: 8];
      for (int i = 0; i < size; i++) we_e[(addr + i) % 4] = 1'b1;
    end
    if (mem_op && is_ld) begin
      for (int i = 0; i < size; i++) rd_e |= 32'(ref_bytes[k][(addr + i) % 1024]) << (8 * i);
      if (!f3[2] && size < 4 && rd_e[8*size-1]) rd_e |= ~((32'd1 << (8 * size)) - 32'd1);
    end

    check("req_ready_idle", 32'(req_ready[k]), 32'd1);
    req_valid[k]  = 1'b1;
    req_inst[k]   = inst;
    req_addr[k]   = addr;
    req_wdata[k]  = wdata;
    resp_ready[k] = (hold == 0);
    @(negedge clk);
    req_valid[k] = 1'b0;
    req_inst[k]  = $urandom;
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    for (int c = 1; c <= lat_exp; c++) begin
      if (c > 1) @(negedge clk);
      check("mem_en", 32'(mem_en[k]), 32'(c == 1 && mem_op));
      check("resp_valid_timing", 32'(resp_valid[k]), 32'(c == lat_exp));
      if (c == 1 && mem_op) begin
        check("mem_addr", 32'(mem_addr[k]), (addr >> 2) & 32'h3FFF);
        check("mem_we", 32'(mem_we[k]), 32'(we_e));
        if (is_st) check("mem_wdata", mem_wdata[k], wd_e);
      end
    end
    if (mem_op && is_st)
      for (int i = 0; i < size; i++) ref_bytes[k][(addr + i) % 1024] = wdata[8*i +: 8];
    check("resp_rdata", resp_rdata[k], rd_e);
    check("resp_fault", 32'(resp_fault[k]), 32'(flt));
    last_rdata = resp_rdata[k];
    for (int h = 0; h < hold; h++) begin
      req_valid[k] = 1'b1;
      req_inst[k]  = st(3'b010);
      @(negedge clk);
      check("hold_valid", 32'(resp_valid[k]), 32'd1);
      check("hold_rdata", resp_rdata[k], rd_e);
      check("hold_fault", 32'(resp_fault[k]), 32'(flt));
      check("hold_ready", 32'(req_ready[k]), 32'd0);
      check("hold_mem_en", 32'(mem_en[k]), 32'd0);
    end
    req_valid[k]  = 1'b0;
    resp_ready[k] = 1'b1;
    @(negedge clk);
    check("back_idle", 32'(req_ready[k]), 32'd1);
    check("resp_dropped", 32'(resp_valid[k]), 32'd0);
  endtask

  initial begin
    logic [31:0] inst, addr, v;
    int          k;
    rst = 1'b1;
    for (int j = 0; j < 2; j++) begin
      req_valid[j] = 1'b0; req_inst[j] = '0; req_addr[j] = '0; req_wdata[j] = '0;
      resp_ready[j] = 1'b1;
      for (int i = 0; i < 1024; i++) ref_bytes[j][i] = 8'h0;
    end
    repeat (2) @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      check("rst_req_ready", 32'(req_ready[j]), 32'd1);
      check("rst_resp_valid", 32'(resp_valid[j]), 32'd0);
      check("rst_mem_en", 32'(mem_en[j]), 32'd0);
      check("rst_mem_we", 32'(mem_we[j]), 32'd0);
      check("rst_rdata", resp_rdata[j], 32'd0);
      check("rst_mem_wdata", mem_wdata[j], 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Word load, byte/half extension, stores with lane enables.
    do_txn(0, st(3'b010), 32'h100, 32'h8000_00FF, 0);
    do_txn(0, ld(3'b010), 32'h100, 32'h0, 0);
    check("lw_literal", last_rdata, 32'h8000_00FF);
    do_txn(0, st(3'b010), 32'h100, 32'h80FF_FF7F, 0);
    do_txn(0, ld(3'b000), 32'h103, 32'h0, 0);
    check("lb_literal", last_rdata, 32'hFFFF_FF80);
    do_txn(0, ld(3'b100), 32'h103, 32'h0, 0);
    check("lbu_literal", last_rdata, 32'h0000_0080);
    do_txn(0, ld(3'b000), 32'h100, 32'h0, 0);
    check("lb0_literal", last_rdata, 32'h0000_007F);
    do_txn(0, st(3'b010), 32'h100, 32'h8001_1234, 0);
    do_txn(0, ld(3'b001), 32'h102, 32'h0, 0);
    check("lh_literal", last_rdata, 32'hFFFF_8001);
    do_txn(0, ld(3'b101), 32'h100, 32'h0, 0);
    check("lhu_literal", last_rdata, 32'h0000_1234);
    do_txn(0, st(3'b000), 32'h201, 32'h1234_56AB, 0);
    do_txn(0, st(3'b001), 32'h202, 32'h1234_56AB, 0);
    do_txn(0, ld(3'b010), 32'h200, 32'h0, 0);
    check("sb_sh_literal", last_rdata, 32'h56AB_AB00);
    // Faults, reserved funct3 and a non-memory opcode.
    do_txn(0, ld(3'b010), 32'h101, 32'h0, 0);
    do_txn(0, st(3'b001), 32'h203, 32'hFFFF_FFFF, 0);
    do_txn(0, ld(3'b110), 32'h100, 32'h0, 0);
    do_txn(0, st(3'b011), 32'h100, 32'h0, 0);
    do_txn(0, 32'h0000_0033, 32'h100, 32'h0, 0);

    // Longer latency instance with a stalled response.
    do_txn(1, st(3'b010), 32'h40, 32'hCAFE_F00D, 0);
    do_txn(1, ld(3'b010), 32'h40, 32'h0, 5);
    do_txn(1, ld(3'b001), 32'h42, 32'h0, 2);

    // Reset while a load waits: no response may appear afterwards.
    req_valid[1] = 1'b1; req_inst[1] = ld(3'b010); req_addr[1] = 32'h40;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstwait_ready", 32'(req_ready[1]), 32'd1);
    check("rstwait_mem_en", 32'(mem_en[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rstwait_no_resp", 32'(resp_valid[1]), 32'd0);
    end

    // Reset during a store's strobe cycle drops the strobe at once.
    v = {ref_bytes[0][771], ref_bytes[0][770], ref_bytes[0][769], ref_bytes[0][768]};
    req_valid[0] = 1'b1; req_inst[0] = st(3'b010); req_addr[0] = 32'h300; req_wdata[0] = v;
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("rstiss_en_before", 32'(mem_en[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("rstiss_mem_en", 32'(mem_en[0]), 32'd0);
    check("rstiss_mem_we", 32'(mem_we[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Randomized traffic on both instances.
    for (int n = 0; n < 300; n++) begin
      k = n % 2;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: inst = ld(3'($urandom_range(0, 7)));
        4, 5, 6, 7, 8: inst = st(3'($urandom_range(0, 3)));
        default: inst = {$urandom} & 32'hFFFF_FFDB;
      endcase
      inst[31:15] = 17'($urandom);
      addr = ({$urandom} & 32'hFFFF_FC00) | 32'($urandom_range(0, 47));
      do_txn(k, inst, addr, $urandom, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
